// File: rtl/hazard_stall_ctrl_if.sv
// Bundle of E-stage sources, M-stage destinations/memory ops and the stall/flush
// controls exchanged between the pipeline and hazard_stall_ctrl.
interface hazard_stall_ctrl_if;
    logic [4:0]  rs1E1, rs2E1, rs1E2, rs2E2;
    logic [3:0]  use_rsE;
    logic        validE1, validE2;
    logic [4:0]  rdM1, rdM2;
    logic        reg_writeM1, reg_writeM2;
    logic [2:0]  mem_loadM1, mem_loadM2;
    logic        mem_storeM1, mem_storeM2;
    logic        dmem_ready;
    logic        stallF, stallD, stallE, stallM;
    logic        flushM, flushW;
    logic        mem_timeout;
    logic [31:0] stall_cycles;

    modport master (
        output rs1E1, rs2E1, rs1E2, rs2E2, use_rsE, validE1, validE2,
               rdM1, rdM2, reg_writeM1, reg_writeM2, mem_loadM1, mem_loadM2,
               mem_storeM1, mem_storeM2, dmem_ready,
        input  stallF, stallD, stallE, stallM, flushM, flushW, mem_timeout, stall_cycles
    );

    modport slave (
        input  rs1E1, rs2E1, rs1E2, rs2E2, use_rsE, validE1, validE2,
               rdM1, rdM2, reg_writeM1, reg_writeM2, mem_loadM1, mem_loadM2,
               mem_storeM1, mem_storeM2, dmem_ready,
        output stallF, stallD, stallE, stallM, flushM, flushW, mem_timeout, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use bubble insertion, memory-wait stall and watchdog for the dual-issue core.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_PERF_EN.
module hazard_stall_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    hazard_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] wait_cnt;
    logic        timeout_q;
    logic        ld1, ld2, mem_op, mwait, lu;
    logic        stall_front, stall_m, flush_m, flush_w;

    function automatic logic src_hit(input logic [4:0] rs);
        return (ld1 && rs == bus.rdM1) || (ld2 && rs == bus.rdM2);
    endfunction

    always_comb begin
        ld1    = (bus.mem_loadM1 != 3'b000) && bus.reg_writeM1 && (bus.rdM1 != 5'd0);
        ld2    = (bus.mem_loadM2 != 3'b000) && bus.reg_writeM2 && (bus.rdM2 != 5'd0);
        mem_op = (bus.mem_loadM1 != 3'b000) || (bus.mem_loadM2 != 3'b000)
                 || bus.mem_storeM1 || bus.mem_storeM2;
        mwait  = mem_op && !bus.dmem_ready;
        lu     = (bus.use_rsE[0] && bus.validE1 && src_hit(bus.rs1E1))
              || (bus.use_rsE[1] && bus.validE1 && src_hit(bus.rs2E1))
              || (bus.use_rsE[2] && bus.validE2 && src_hit(bus.rs1E2))
              || (bus.use_rsE[3] && bus.validE2 && src_hit(bus.rs2E2));
    end

    // Memory stall and the watchdog fault outrank the load-use bubble.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        stall_front = 1'b0;
        stall_m     = 1'b0;
        flush_m     = 1'b0;
        flush_w     = 1'b0;
        if (!reset) begin
            if (state == ERROR || mwait) begin
                stall_front = 1'b1;
                stall_m     = 1'b1;
                flush_w     = 1'b1;
            end else if (lu) begin
                stall_front = 1'b1;
                flush_m     = 1'b1;
            end
        end
    end

    assign bus.stallF      = stall_front;
    assign bus.stallD      = stall_front;
    assign bus.stallE      = stall_front;
    assign bus.stallM      = stall_m;
    assign bus.flushM      = flush_m;
    assign bus.flushW      = flush_w;
    assign bus.mem_timeout = timeout_q && !reset;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
        if (reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mwait) begin
                        state <= MEM_WAIT;
                        if (wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (!mwait) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        if (wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
                        if (wait_cnt == LAST_WAIT) begin
                            state     <= ERROR;
                            timeout_q <= 1'b1;
                        end
                    end
                end
                ERROR:   state <= ERROR;
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_STALL_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall_front && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign bus.stall_cycles = stall_cnt;
`else
    assign bus.stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed scoreboard bench for hazard_stall_ctrl with TIMEOUT=4.
module tb_hazard_stall_ctrl;
    typedef struct {
        string       name;
        logic [3:0]  stalls;   // {F,D,E,M}
        logic        flush_m;
        logic        flush_w;
        logic        timeout;
        logic [31:0] cycles;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    hazard_stall_ctrl_if bus ();

    hazard_stall_ctrl #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pc(input int n);
`ifdef HAZARD_STALL_PERF_EN
        return 32'(n);
`else
        return 32'd0 + 32'(n * 0);
`endif
    endfunction

    // Monitor: the DUT presents a response every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t        e;
            logic [6:0]  act, req;
            e   = sb_q.pop_front();
            act = {bus.stallF, bus.stallD, bus.stallE, bus.stallM,
                   bus.flushM, bus.flushW, bus.mem_timeout};
            req = {e.stalls, e.flush_m, e.flush_w, e.timeout};
            total++;
            if (act !== req || bus.stall_cycles !== e.cycles) begin
                bad++;
                $display("FAIL %s: got ctl=%b cycles=%0d, want ctl=%b cycles=%0d",
                         e.name, act, bus.stall_cycles, req, e.cycles);
            end
        end
    end

    task automatic clr();
        bus.rs1E1 = 0; bus.rs2E1 = 0; bus.rs1E2 = 0; bus.rs2E2 = 0;
        bus.use_rsE = 4'b0; bus.validE1 = 0; bus.validE2 = 0;
        bus.rdM1 = 0; bus.rdM2 = 0; bus.reg_writeM1 = 0; bus.reg_writeM2 = 0;
        bus.mem_loadM1 = 3'b0; bus.mem_loadM2 = 3'b0;
        bus.mem_storeM1 = 0; bus.mem_storeM2 = 0; bus.dmem_ready = 1'b1;
    endtask

    task automatic load_use_setup();
        clr();
        bus.mem_loadM1 = 3'b010; bus.rdM1 = 5'd5; bus.reg_writeM1 = 1'b1;
        bus.rs2E2 = 5'd5; bus.use_rsE = 4'b1000; bus.validE2 = 1'b1;
    endtask

    // Inputs are already applied; record what the DUT must show this cycle.
    task automatic step(input string nm, input logic [3:0] st, input logic fm,
                        input logic fw, input logic to, input int n);
        exp_t e;
        e.name = nm; e.stalls = st; e.flush_m = fm; e.flush_w = fw;
        e.timeout = to; e.cycles = pc(n);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        reset = 1'b1;
        bus.mem_storeM1 = 1'b1; bus.dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        step("reset_hold", 4'b0000, 0, 0, 0, 0);

        // Load-use bubble and its single-cycle duration.
        reset = 1'b0;
        load_use_setup();
        step("lu_bubble", 4'b1110, 1, 0, 0, 0);
        clr();
        step("lu_after", 4'b0000, 0, 0, 0, 1);

        load_use_setup(); bus.rdM1 = 5'd0;
        step("no_hazard_x0", 4'b0000, 0, 0, 0, 1);
        load_use_setup(); bus.mem_loadM1 = 3'b000;
        step("no_hazard_nonload", 4'b0000, 0, 0, 0, 1);
        load_use_setup(); bus.use_rsE = 4'b0000;
        step("no_hazard_unused", 4'b0000, 0, 0, 0, 1);
        load_use_setup(); bus.validE2 = 1'b0;
        step("no_hazard_bubble_lane", 4'b0000, 0, 0, 0, 1);

        clr();
        bus.mem_loadM1 = 3'b100; bus.rdM1 = 5'd7; bus.reg_writeM1 = 1'b1;
        bus.mem_loadM2 = 3'b001; bus.rdM2 = 5'd7; bus.reg_writeM2 = 1'b1;
        bus.rs1E1 = 5'd7; bus.use_rsE = 4'b0001; bus.validE1 = 1'b1;
        step("dual_lu_bubble", 4'b1110, 1, 0, 0, 1);
        clr();
        step("dual_lu_after", 4'b0000, 0, 0, 0, 2);

        // Memory wait with a pending load-use hazard.
        reset = 1'b1;
        step("reset_clears", 4'b0000, 0, 0, 0, 2);
        reset = 1'b0;
        load_use_setup(); bus.dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("mwait_stall", 4'b1111, 0, 1, 0, i);
        bus.dmem_ready = 1'b1;
        step("mwait_then_bubble", 4'b1110, 1, 0, 0, 3);
        clr();
        step("mwait_run", 4'b0000, 0, 0, 0, 4);

        // Watchdog trips after four not-ready cycles and is sticky.
        reset = 1'b1;
        step("reset_before_to", 4'b0000, 0, 0, 0, 4);
        reset = 1'b0;
        clr(); bus.mem_storeM1 = 1'b1; bus.dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) step("to_wait", 4'b1111, 0, 1, 0, i);
        step("to_tripped", 4'b1111, 0, 1, 1, 4);
        step("to_held", 4'b1111, 0, 1, 1, 5);
        bus.dmem_ready = 1'b1;
        step("to_sticky_ready", 4'b1111, 0, 1, 1, 6);
        clr();
        step("to_sticky_idle", 4'b1111, 0, 1, 1, 7);
        reset = 1'b1;
        step("to_reset_cycle", 4'b0000, 0, 0, 0, 8);
        reset = 1'b0;
        step("to_cleared", 4'b0000, 0, 0, 0, 0);

        // Ready in the fourth cycle avoids the timeout.
        bus.mem_storeM1 = 1'b1; bus.dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("bound_wait", 4'b1111, 0, 1, 0, i);
        bus.dmem_ready = 1'b1;
        step("bound_ready", 4'b0000, 0, 0, 0, 3);
        clr();
        step("bound_run", 4'b0000, 0, 0, 0, 3);

        // Reset in the second not-ready cycle, then a fresh full wait.
        bus.mem_storeM1 = 1'b1; bus.dmem_ready = 1'b0;
        step("midrst_wait", 4'b1111, 0, 1, 0, 3);
        reset = 1'b1;
        step("midrst_reset", 4'b0000, 0, 0, 0, 4);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step("midrst_fresh_wait", 4'b1111, 0, 1, 0, i);
        step("midrst_trip", 4'b1111, 0, 1, 1, 4);
        reset = 1'b1;
        step("final_reset", 4'b0000, 0, 0, 0, 5);

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall controller for the dual-issue RV32I core, working alongside the E-stage forwarding unit. The forwarding unit never forwards load results from M, so this block detects E-stage reads of a register that an M-stage load will write and inserts one bubble. After that bubble, the forwarding unit picks the value up from W. The block also holds the pipeline while data memory is not ready, runs a memory-wait watchdog, and can optionally count stall cycles.

## Interface
- `TIMEOUT`, default 255: number of consecutive memory not-ready cycles before a fatal timeout; legal range 2..65535.
- `clk`  in  1  single core clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rs1E1`, `rs2E1`, `rs1E2`, `rs2E2`  in  5 each  source register numbers of E lane 1 and E lane 2.
- `use_rsE`  in  4  source-valid bits: [0]=rs1E1, [1]=rs2E1, [2]=rs1E2, [3]=rs2E2.
- `validE1`, `validE2`  in  1 each  E lane holds a real instruction (not a bubble).
- `rdM1`, `rdM2`  in  5 each  destination registers in M; lane 2 is the younger lane.
- `reg_writeM1`, `reg_writeM2`  in  1 each  M lane writes the register file.
- `mem_loadM1`, `mem_loadM2`  in  3 each  load type; 3'b000 means not a load.
- `mem_storeM1`, `mem_storeM2`  in  1 each  M lane is a store.
- `dmem_ready`  in  1  data memory completes the current M access this cycle.
- `stallF`, `stallD`, `stallE`, `stallM`  out  1 each  hold the pipeline register of that stage.
- `flushM`  out  1  load a bubble into M at the next edge.
- `flushW`  out  1  load a bubble into W at the next edge.
- `mem_timeout`  out  1  sticky fatal flag.
- `stall_cycles`  out  32  performance counter of stall cycles.

## Operation
- Signals used below:
  - `ldM(i)` = (`mem_loadM_i`!=0) & `reg_writeM_i` & (`rdM_i`!=0).
  - `mem_opM` = any `mem_loadM_i`!=0, or any `mem_storeM_i`.
  - `mwait` = `mem_opM` & !`dmem_ready`.
- Load-use hazard `lu`: some E source has its `use_rsE` bit set, its lane's `validE` set, and it equals an `rdM_i` where `ldM(i)` holds. Both lanes stall together because bundles stay in order.
- FSM states: RUN, MEM_WAIT, ERROR. Reset puts it in RUN.
  - RUN → MEM_WAIT when `mwait`.
  - MEM_WAIT → RUN when !`mwait`.
  - MEM_WAIT → ERROR when `mwait` and `wait_cnt`==`TIMEOUT`-1.
  - ERROR is left only by reset.
- `wait_cnt` is 16 bits wide.
  - Cleared in RUN whenever !`mwait`.
  - Increments each cycle that `mwait` is true in RUN or MEM_WAIT.
  - Never wraps.
- Outputs (all combinational from the current state and inputs):
  - ERROR: `stallF`/`stallD`/`stallE`/`stallM`=1, `flushW`=1, `flushM`=0, `mem_timeout`=1.
  - `mwait` (RUN or MEM_WAIT): `stallF`/`stallD`/`stallE`/`stallM`=1, `flushW`=1, `flushM`=0. A memory stall takes priority over `lu`.
  - `lu` & !`mwait`: `stallF`/`stallD`/`stallE`=1, `stallM`=0, `flushM`=1, `flushW`=0.
  - Otherwise all stall and flush outputs are 0.
- `mem_timeout` is set on entry to ERROR and cleared only by reset.

## Timing
- Stall and flush outputs react in the same cycle as their inputs (zero latency). State and counters update at the next edge.
- During any cycle with `reset`=1:
  - All stall and flush outputs are 0 and `mem_timeout`=0.
  - At the edge: state=RUN, `wait_cnt`=0, `mem_timeout`=0, `stall_cycles`=0.
  - This applies even mid-wait or in ERROR.
- A load-use bubble lasts exactly one cycle. At the next edge the load reaches W, `lu` drops, and the forwarding unit supplies the W value.
- A load in M with `dmem_ready` low for N cycles gives N cycles of full stall, then the `lu` bubble, if one is needed, in the cycle where `dmem_ready`=1.
- With `TIMEOUT`=T, T consecutive `mwait` cycles make `mem_timeout`=1 from cycle T+1 onward. If `dmem_ready` rises in cycle T, the timeout does not occur.
- `rdM`=0 never creates a hazard. A load in both M lanes writing the same rd creates a single one-cycle bubble.

## Configuration
- `HAZARD_STALL_PERF_EN` defined:
  - `stall_cycles` increments by 1 at each edge where `stallF`=1 and `reset`=0.
  - It saturates at 32'hFFFF_FFFF.
- `HAZARD_STALL_PERF_EN` undefined:
  - No counter register is built.
  - `stall_cycles` is tied to 32'd0.
  - All other behaviour is identical.

## Test plan
- Load-use: M1 is a load (`mem_loadM1`=3'b010, `rdM1`=5, `reg_writeM1`=1), `rs2E2`=5, `use_rsE`[3]=1, `validE2`=1, `dmem_ready`=1 -> one cycle with `stallF`/`stallD`/`stallE`=1, `flushM`=1, `stallM`=0; all outputs 0 the next cycle.
- No hazard on x0 or non-loads:
  - Same setup with `rdM1`=0 -> all outputs 0.
  - Same setup with `mem_loadM1`=0 and `reg_writeM1`=1 -> all outputs 0.
  - Same setup with `use_rsE`[3]=0 -> all outputs 0.
- Memory wait with pending hazard: load in M, `dmem_ready` low for 3 cycles, then high -> 3 cycles of all four stalls plus `flushW`, then 1 bubble cycle (`flushM`=1), then run; `stall_cycles`=4 when `HAZARD_STALL_PERF_EN` is defined, else 0.
- Timeout: `TIMEOUT`=4, store in M, `dmem_ready` held at 0 -> `mem_timeout`=1 from cycle 5. It stays 1 and all stalls stay 1 after `dmem_ready` rises. Asserting `reset` for one cycle clears everything.
- Timeout boundary: `TIMEOUT`=4, `dmem_ready` low for 3 cycles and high in cycle 4 -> `mem_timeout` stays 0 and the FSM returns to RUN.
- Reset mid-wait: `reset` asserted in the second not-ready cycle -> stall outputs are 0 that cycle. After reset, a fresh wait needs a full `TIMEOUT` cycles to trip.
